hc_write_arbiter: RTL and testbench
===================================

# hc_write_arbiter

Round-robin arbiter that lets up to N_REQ user cores share the single write-request port of the host-channel requestor. It drives `core_buffer.write_request.control` and `core_buffer.tx_buffer_data`, and obeys the requestor's registered full status. Once every requester reports done and the write FIFO has drained, it asserts `finish`, which triggers the requestor's DSM completion write.

## Interface

Parameters:
- N_REQ, 4: number of requesters; 2..8.
- DRAIN_CYCLES, 3: consecutive empty cycles required before `finish`. Covers the FIFO counter and status register latency.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  requestor start level; deassertion aborts to S_IDLE
- req_valid  in  N_REQ  request present, one bit per requester
- req_cmd  in  N_REQ x t_request_cmd  e_REQUEST_WRITE_STREAM or e_REQUEST_WRITE_INDEXED
- req_id  in  N_REQ x t_hc_buffer_id  target buffer index
- req_offset  in  N_REQ x t_ccip_clAddr  cache-line offset (indexed only)
- req_data  in  N_REQ x t_ccip_clData  line payload
- req_ready  out  N_REQ  grant; a transfer happens when valid & ready
- req_done  in  N_REQ  requester has issued its last write (level)
- wr_full  in  1  `write_request.status.full`
- wr_empty  in  1  `write_request.status.empty`
- out_cmd  out  t_request_cmd  to `write_request.control.cmd`
- out_id  out  t_hc_buffer_id  to `write_request.control.id`
- out_offset  out  t_ccip_clAddr  to `write_request.control.offset`
- out_data  out  t_ccip_clData  to `tx_buffer_data.cl_data`
- finish  out  1  all writes drained
- bad_cmd  out  1  sticky: a non-write command was accepted
- grant_count  out  32  total accepted writes; wraps

## Operation

- FSM states: S_IDLE, S_RUN, S_DRAIN, S_DONE.
- S_IDLE → S_RUN when start = 1.
- Any state → S_IDLE when start = 0. This also clears the RR pointer, DRAIN counter, bad_cmd and grant_count.
- Arbitration runs only in S_RUN, and only when wr_full = 0.
  - Candidates are requesters with req_valid = 1.
  - Search starts at rr_ptr: first match from rr_ptr, rr_ptr+1, …, modulo N_REQ.
  - At most one req_ready bit is high per cycle. req_ready is combinational from req_valid, rr_ptr, wr_full and state.
- On a transfer from requester g:
  - rr_ptr ← (g+1) mod N_REQ.
  - grant_count increments.
- Requester obligation: cmd, id, offset and data stay stable while valid = 1 and ready = 0. Valid must not drop before the transfer.
- Accepted command that is not a write: out_cmd = e_REQUEST_NONE (nothing enqueued), bad_cmd ← 1. The command still counts as a grant and advances rr_ptr.
- S_RUN → S_DRAIN when all req_done = 1 and req_valid = 0 in the same cycle.
- In S_DRAIN:
  - Count consecutive cycles with wr_empty = 1 and out_cmd = NONE; any other cycle clears the count.
  - Reaching DRAIN_CYCLES → S_DONE.
  - A req_valid seen in S_DRAIN returns the FSM to S_RUN.
- S_DONE: finish = 1, held until start = 0 or reset.

## Timing

- Output registers: out_* are registered. A transfer at cycle t produces out_cmd and its payload at t+1 for exactly one cycle; otherwise out_cmd = e_REQUEST_NONE.
- Throughput: back-to-back grants are allowed, one per cycle.
- Full threshold: wr_full is asserted at FIFO count > depth−5. The ≤2-cycle status lag therefore cannot overflow the FIFO.
- Fairness: wr_full rising in the same cycle as valid produces no grant, and rr_pointer is unchanged.
- Reset values: req_ready = 0, out_cmd = e_REQUEST_NONE, out_id/offset/data = 0, finish = 0, bad_cmd = 0, grant_count = 0, rr_ptr = 0, state = S_IDLE.
- Reset mid-transfer: a request in flight is discarded; the requester must reissue it.
- `finish` latency: earliest DRAIN_CYCLES+1 cycles after the last out_cmd write.

## Structure

- hc_pkg additions:
  - t_arb_state enum.
  - t_request_cmd, including e_REQUEST_NONE.
  - t_hc_buffer_id.
  - HC_ARB_DRAIN_CYCLES constant.
- Sub-module: hc_rr_arbiter (N-way round-robin pick: valid vector and pointer in; one-hot grant and index out). It is combinational and reused later for read arbitration.
- Top module holds the FSM, output register stage, counters and mux.

## Test plan

- Single requester: req0 streams 8 writes, wr_full = 0 → out_cmd valid for 8 consecutive cycles; grant_count = 8; out_data matches per cycle.
- Fairness: all 4 requesters held valid for 12 cycles → grants ordered 0,1,2,3,0,1,2,3,…; each requester gets 3.
- Backpressure: wr_full = 1 for cycles 5–9 while valid → req_ready = 0 and out_cmd = NONE throughout; on release the grant goes to the same requester it would have gone to, and payload is unchanged.
- Bad command: requester 2 presents a read command → out_cmd = NONE, bad_cmd = 1 (sticky), rr_ptr = 3.
- Finish: all req_done set, wr_empty held at 1 → finish rises 3 cycles after entering S_DRAIN. A req_valid pulse during S_DRAIN → back to S_RUN, finish stays 0.
- Abort: deassert start in S_RUN mid-stream, and separately assert async reset → all outputs reach reset values, state = S_IDLE.

Source files
------------

// File: rtl/hc_write_arbiter_pkg.sv
// Shared types for the host-channel write arbiter: request commands, buffer ids,
// CCI-P line types and the arbiter FSM encoding.
package hc_write_arbiter_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [3:0]   t_hc_buffer_id;

  typedef enum logic [2:0] {
    e_REQUEST_NONE          = 3'd0,
    e_REQUEST_READ          = 3'd1,
    e_REQUEST_WRITE_STREAM  = 3'd2,
    e_REQUEST_WRITE_INDEXED = 3'd3
  } t_request_cmd;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } t_arb_state;

  // Empty cycles needed to cover the FIFO counter plus status register latency.
  localparam int HC_ARB_DRAIN_CYCLES = 3;

  function automatic logic is_write_cmd(input t_request_cmd cmd);
    return (cmd == e_REQUEST_WRITE_STREAM) || (cmd == e_REQUEST_WRITE_INDEXED);
  endfunction

endpackage

// File: rtl/hc_write_arbiter_if.sv
// Requester-side bundle of the write arbiter: one valid/ready/done lane and one
// command+payload slot per user core.
interface hc_write_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import hc_write_arbiter_pkg::*;

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] req_done;
  t_request_cmd     req_cmd    [N_REQ];
  t_hc_buffer_id    req_id     [N_REQ];
  t_ccip_clAddr     req_offset [N_REQ];
  t_ccip_clData     req_data   [N_REQ];

  modport master (
    output req_valid, req_done, req_cmd, req_id, req_offset, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_done, req_cmd, req_id, req_offset, req_data,
    output req_ready
  );

endinterface

// File: rtl/hc_write_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick: first valid requester at or after ptr_i,
// wrapping modulo N. Shared by the write path and the later read arbiter.
module hc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int PW = $clog2(N);

  logic [PW:0]   pos;
  logic [PW-1:0] cand;

  // One extra bit on pos lets ptr+k exceed N-1 before folding back, so
  // non-power-of-two N wraps correctly.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      cand = pos[PW-1:0];
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/hc_write_arbiter.sv
// Round-robin share of the host-channel write-request port among N_REQ cores,
// with registered command/payload outputs and a drain check that raises finish.
module hc_write_arbiter
  import hc_write_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DRAIN_CYCLES = HC_ARB_DRAIN_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  hc_write_arbiter_if.slave   req,
  input  logic                wr_full,
  input  logic                wr_empty,
  output t_request_cmd        out_cmd,
  output t_hc_buffer_id       out_id,
  output t_ccip_clAddr        out_offset,
  output t_ccip_clData        out_data,
  output logic                finish,
  output logic                bad_cmd,
  output logic [31:0]         grant_count
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  t_arb_state    state_q;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [CW-1:0] drain_cnt_q;
  logic [CW-1:0] drain_cnt_d;
  t_request_cmd  out_cmd_q;
  t_hc_buffer_id out_id_q;
  t_ccip_clAddr  out_offset_q;
  t_ccip_clData  out_data_q;
  logic          finish_q;
  logic          bad_cmd_q;
  logic [31:0]   grant_count_q;

  logic [N_REQ-1:0] grant_oh;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic             arb_en;
  logic             xfer;
  logic             all_done_idle;
  t_request_cmd     sel_cmd;

  hc_rr_arbiter #(.N(N_REQ)) u_rr (
    .valid_i (req.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // A full FIFO blocks the grant outright, so the pointer stays put and the
  // same requester wins once space returns.
  assign arb_en        = (state_q == S_RUN) && !wr_full;
  assign req.req_ready = arb_en ? grant_oh : '0;
  assign xfer          = arb_en && grant_any;
  assign sel_cmd       = req.req_cmd[grant_idx];
  assign all_done_idle = (&req.req_done) && !(|req.req_valid);
  assign rr_ptr_d      = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
  assign drain_cnt_d   = drain_cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      drain_cnt_q   <= '0;
      out_cmd_q     <= e_REQUEST_NONE;
      out_id_q      <= '0;
      out_offset_q  <= '0;
      out_data_q    <= '0;
      finish_q      <= 1'b0;
      bad_cmd_q     <= 1'b0;
      grant_count_q <= '0;
    end else if (!start) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      drain_cnt_q   <= '0;
      out_cmd_q     <= e_REQUEST_NONE;
      out_id_q      <= '0;
      out_offset_q  <= '0;
      out_data_q    <= '0;
      finish_q      <= 1'b0;
      bad_cmd_q     <= 1'b0;
      grant_count_q <= '0;
    end else begin
      out_cmd_q <= e_REQUEST_NONE;
      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (xfer) begin
            // Non-write commands still consume the grant but enqueue nothing.
            out_cmd_q     <= is_write_cmd(sel_cmd) ? sel_cmd : e_REQUEST_NONE;
            out_id_q      <= req.req_id[grant_idx];
            out_offset_q  <= req.req_offset[grant_idx];
            out_data_q    <= req.req_data[grant_idx];
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= grant_count_q + 32'd1;
            if (!is_write_cmd(sel_cmd)) begin
              bad_cmd_q <= 1'b1;
            end
          end
          if (all_done_idle) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          if (|req.req_valid) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
          end else if (wr_empty && (out_cmd_q == e_REQUEST_NONE)) begin
            drain_cnt_q <= drain_cnt_d;
            if (drain_cnt_d == CW'(DRAIN_CYCLES)) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
            end
          end else begin
            drain_cnt_q <= '0;
          end
        end
        default: begin
          finish_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_cmd     = out_cmd_q;
  assign out_id      = out_id_q;
  assign out_offset  = out_offset_q;
  assign out_data    = out_data_q;
  assign finish      = finish_q;
  assign bad_cmd     = bad_cmd_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_hc_write_arbiter.sv
// Bench for hc_write_arbiter: scenario table plus hand-written drain, abort and
// reset sequences, checked against a cycle model and an output scoreboard.
module tb_hc_write_arbiter;
  import hc_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DC = HC_ARB_DRAIN_CYCLES;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          wr_full;
  logic          wr_empty;
  t_request_cmd  out_cmd;
  t_hc_buffer_id out_id;
  t_ccip_clAddr  out_offset;
  t_ccip_clData  out_data;
  logic          finish;
  logic          bad_cmd;
  logic [31:0]   grant_count;

  hc_write_arbiter_if #(.N_REQ(N)) ifc ();

  hc_write_arbiter #(.N_REQ(N), .DRAIN_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .req         (ifc.slave),
    .wr_full     (wr_full),
    .wr_empty    (wr_empty),
    .out_cmd     (out_cmd),
    .out_id      (out_id),
    .out_offset  (out_offset),
    .out_data    (out_data),
    .finish      (finish),
    .bad_cmd     (bad_cmd),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    t_request_cmd  cmd;
    t_hc_buffer_id id;
    t_ccip_clAddr  off;
    t_ccip_clData  data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int   n0, n1, n2, n3;
    int   bad_req;
    int   idx_req;
    int   flo, fhi;
    int   exp_gc;
    logic exp_bad;
  } vec_t;
  vec_t tbl[5];

  int           left  [N];
  int           seq   [N];
  int           xfers [N];
  t_request_cmd kind  [N];
  logic         done_en;
  int           cyc;
  int           full_lo, full_hi;

  t_arb_state   m_state;
  int           m_ptr;
  int           m_cnt;
  logic         m_bad;
  logic         m_fin;
  logic [31:0]  m_gc;

  function automatic t_ccip_clData mk_data(input int r, input int s);
    return {16{8'(r), 24'(s)}};
  endfunction

  function automatic t_ccip_clAddr mk_off(input int r, input int s);
    return {10'(r), 32'(s)};
  endfunction

  function automatic t_hc_buffer_id mk_id(input int r, input int s);
    return t_hc_buffer_id'(r * 4 + s);
  endfunction

  function automatic logic tb_is_write(input t_request_cmd c);
    return (c == e_REQUEST_WRITE_STREAM) || (c == e_REQUEST_WRITE_INDEXED);
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_state = S_IDLE;
    m_ptr   = 0;
    m_cnt   = 0;
    m_bad   = 1'b0;
    m_fin   = 1'b0;
    m_gc    = '0;
    sb.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifc.req_valid[i]  = (left[i] > 0);
      ifc.req_cmd[i]    = kind[i];
      ifc.req_id[i]     = mk_id(i, seq[i]);
      ifc.req_offset[i] = mk_off(i, seq[i]);
      ifc.req_data[i]   = mk_data(i, seq[i]);
      ifc.req_done[i]   = done_en;
    end
    wr_full = (cyc >= full_lo) && (cyc <= full_hi);
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    logic [N-1:0] xobs;
    int           g;
    int           j;
    exp_t         e;
    t_request_cmd cur;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (m_state == S_RUN && !wr_full) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && ifc.req_valid[j]) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 512'(ifc.req_ready), 512'(er));
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      cur = e.cmd;
      chk("out_cmd", 512'(out_cmd), 512'(e.cmd));
      if (e.cmd != e_REQUEST_NONE) begin
        chk("out_id", 512'(out_id), 512'(e.id));
        chk("out_offset", 512'(out_offset), 512'(e.off));
        chk("out_data", out_data, e.data);
      end
    end else begin
      cur = e_REQUEST_NONE;
      chk("out_cmd_idle", 512'(out_cmd), 512'(e_REQUEST_NONE));
    end
    chk("finish", 512'(finish), 512'(m_fin));
    chk("bad_cmd", 512'(bad_cmd), 512'(m_bad));
    chk("grant_count", 512'(grant_count), 512'(m_gc));
    chk("rr_ptr", 512'(dut.rr_ptr_q), 512'(m_ptr));
    chk("state", 512'(dut.state_q), 512'(m_state));
    xobs = ifc.req_valid & ifc.req_ready;
    if (reset || !start) begin
      model_clear();
    end else begin
      case (m_state)
        S_IDLE: m_state = S_RUN;
        S_RUN: begin
          if (g >= 0) begin
            e.cmd  = tb_is_write(kind[g]) ? kind[g] : e_REQUEST_NONE;
            e.id   = mk_id(g, seq[g]);
            e.off  = mk_off(g, seq[g]);
            e.data = mk_data(g, seq[g]);
            sb.push_back(e);
            m_ptr = (g + 1) % N;
            m_gc  = m_gc + 32'd1;
            if (!tb_is_write(kind[g])) m_bad = 1'b1;
          end
          if ((&ifc.req_done) && (ifc.req_valid == '0)) begin
            m_state = S_DRAIN;
            m_cnt   = 0;
          end
        end
        S_DRAIN: begin
          if (|ifc.req_valid) begin
            m_state = S_RUN;
            m_cnt   = 0;
          end else if (wr_empty && cur == e_REQUEST_NONE) begin
            m_cnt++;
            if (m_cnt == DC) begin
              m_state = S_DONE;
              m_fin   = 1'b1;
            end
          end else begin
            m_cnt = 0;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xobs[i]) begin
        left[i]--;
        seq[i]++;
        xfers[i]++;
      end
    end
    cyc++;
    drive();
  endtask

  function automatic logic any_left();
    logic a = 1'b0;
    for (int i = 0; i < N; i++) if (left[i] > 0) a = 1'b1;
    return a;
  endfunction

  task automatic restart();
    start   = 1'b0;
    done_en = 1'b0;
    cyc     = 0;
    for (int i = 0; i < N; i++) begin
      left[i]  = 0;
      seq[i]   = 0;
      xfers[i] = 0;
      kind[i]  = e_REQUEST_WRITE_STREAM;
    end
    full_lo = -1;
    full_hi = -1;
    drive();
    cycle();
    start = 1'b1;
    cyc   = 0;
    drive();
  endtask

  task automatic stream_out(input string nm);
    int guard = 0;
    while (any_left() && guard < 300) begin
      cycle();
      guard++;
    end
    if (guard >= 300) chk({nm, "_stream_timeout"}, 512'(1), 512'(0));
  endtask

  task automatic wait_finish(input string nm, input int exp_lat);
    int fin_at = -1;
    done_en = 1'b1;
    drive();
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (finish === 1'b1) begin
        fin_at = k;
        break;
      end
    end
    if (exp_lat >= 0) chk({nm, "_finish_latency"}, 512'(fin_at), 512'(exp_lat));
    chk({nm, "_finish_seen"}, 512'(finish), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8, 0, 0, 0, -1, -1, -1, -1,  8, 1'b0};  // single requester stream
    tbl[1] = '{3, 3, 3, 3, -1, -1, -1, -1, 12, 1'b0};  // fairness
    tbl[2] = '{4, 4, 0, 0, -1, -1,  5,  9,  8, 1'b0};  // backpressure
    tbl[3] = '{0, 0, 1, 1,  2, -1, -1, -1,  2, 1'b1};  // read command from req 2
    tbl[4] = '{2, 1, 3, 2, -1,  1,  2,  3,  8, 1'b0};  // mixed, indexed writes

    reset    = 1'b1;
    start    = 1'b0;
    wr_empty = 1'b1;
    done_en  = 1'b0;
    cyc      = 0;
    full_lo  = -1;
    full_hi  = -1;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; seq[i] = 0; xfers[i] = 0; kind[i] = e_REQUEST_WRITE_STREAM;
    end
    drive();
    model_clear();
    #12;
    chk("rst_out_cmd", 512'(out_cmd), 512'(e_REQUEST_NONE));
    chk("rst_grant_count", 512'(grant_count), 512'(0));
    chk("rst_finish", 512'(finish), 512'(0));
    chk("rst_bad_cmd", 512'(bad_cmd), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      restart();
      left[0] = tbl[v].n0; left[1] = tbl[v].n1; left[2] = tbl[v].n2; left[3] = tbl[v].n3;
      if (tbl[v].bad_req >= 0) kind[tbl[v].bad_req] = e_REQUEST_READ;
      if (tbl[v].idx_req >= 0) kind[tbl[v].idx_req] = e_REQUEST_WRITE_INDEXED;
      full_lo = tbl[v].flo;
      full_hi = tbl[v].fhi;
      drive();
      stream_out($sformatf("vec%0d", v));
      wait_finish($sformatf("vec%0d", v), DC);
      chk($sformatf("vec%0d_grant_count", v), 512'(grant_count), 512'(tbl[v].exp_gc));
      chk($sformatf("vec%0d_bad_cmd", v), 512'(bad_cmd), 512'(tbl[v].exp_bad));
      chk($sformatf("vec%0d_share0", v), 512'(xfers[0]), 512'(tbl[v].n0));
      chk($sformatf("vec%0d_share3", v), 512'(xfers[3]), 512'(tbl[v].n3));
    end

    // A request arriving during drain pulls the FSM back to RUN.
    restart();
    left[1] = 2;
    drive();
    stream_out("drain_irq");
    done_en = 1'b1;
    drive();
    cycle();
    cycle();
    left[1] = 1;
    drive();
    cycle();
    chk("drain_irq_state_run", 512'(dut.state_q), 512'(S_RUN));
    chk("drain_irq_finish_low", 512'(finish), 512'(0));
    stream_out("drain_irq2");
    wait_finish("drain_irq", -1);
    chk("drain_irq_grant_count", 512'(grant_count), 512'(3));

    // Dropping start mid-stream aborts to IDLE with cleared outputs.
    restart();
    left[0] = 10;
    drive();
    for (int k = 0; k < 4; k++) cycle();
    start = 1'b0;
    drive();
    cycle();
    chk("abort_out_cmd", 512'(out_cmd), 512'(e_REQUEST_NONE));
    chk("abort_grant_count", 512'(grant_count), 512'(0));
    chk("abort_state", 512'(dut.state_q), 512'(S_IDLE));
    chk("abort_req_ready", 512'(ifc.req_ready), 512'(0));
    chk("abort_out_data", out_data, 512'(0));

    // Asynchronous reset mid-stream, then the stream resumes.
    restart();
    left[0] = 10;
    drive();
    for (int k = 0; k < 4; k++) cycle();
    reset = 1'b1;
    #2;
    chk("areset_out_cmd", 512'(out_cmd), 512'(e_REQUEST_NONE));
    chk("areset_out_id", 512'(out_id), 512'(0));
    chk("areset_out_offset", 512'(out_offset), 512'(0));
    chk("areset_out_data", out_data, 512'(0));
    chk("areset_grant_count", 512'(grant_count), 512'(0));
    chk("areset_state", 512'(dut.state_q), 512'(S_IDLE));
    chk("areset_rr_ptr", 512'(dut.rr_ptr_q), 512'(0));
    chk("areset_req_ready", 512'(ifc.req_ready), 512'(0));
    model_clear();
    cycle();
    reset = 1'b0;
    stream_out("areset");
    wait_finish("areset", DC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
